// File: rtl/parallel_in_serial_out_tx.sv
// Parallel-in / serial-out transmitter: accepts a DATA_WIDTH word and shifts it out MSB first.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module parallel_in_serial_out_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Load_Valid_In,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    output logic                  Ready_Out,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Frame_Done_Out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic r_Parity, r_Parity_d;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t                r_State, r_State_d;
    logic [DATA_WIDTH-1:0] r_Shift_Register, r_Shift_Register_d;
    logic [CNT_W-1:0]      r_Bit_Count, r_Bit_Count_d;

    logic in_frame;
    logic last_bit;
    logic ser_bit;
    logic accept;

    always_comb begin
        in_frame = 1'b0;
        last_bit = 1'b0;
        ser_bit  = 1'b0;
        case (r_State)
            SHIFT: begin
                in_frame = 1'b1;
                ser_bit  = r_Shift_Register[DATA_WIDTH-1];
`ifndef PISO_TX_PARITY_EN
                last_bit = (r_Bit_Count == LAST_BIT);
`endif
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                in_frame = 1'b1;
                ser_bit  = r_Parity;
                last_bit = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // A new word may be taken while the final frame bit is on the line, giving gapless frames.
    assign Ready_Out        = Enable_In && ((r_State == IDLE) || last_bit);
    assign accept           = Ready_Out && Load_Valid_In;
    assign Serial_Valid_Out = Enable_In && Reset_In && in_frame;
    assign Frame_Done_Out   = Enable_In && Reset_In && last_bit;
    assign Serial_Data_Out  = Enable_In ? (Reset_In && ser_bit) : 1'bz;

    always_comb begin
        r_State_d          = r_State;
        r_Shift_Register_d = r_Shift_Register;
        r_Bit_Count_d      = r_Bit_Count;
`ifdef PISO_TX_PARITY_EN
        r_Parity_d         = r_Parity;
`endif
        if (Enable_In) begin
            if (accept) begin
                r_State_d          = SHIFT;
                r_Shift_Register_d = Parallel_Data_In;
                r_Bit_Count_d      = '0;
`ifdef PISO_TX_PARITY_EN
                r_Parity_d         = ^Parallel_Data_In;
`endif
            end else begin
                case (r_State)
                    SHIFT: begin
                        if (r_Bit_Count == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
                            r_State_d = PARITY;
`else
                            r_State_d = IDLE;
`endif
                        end else begin
                            r_Shift_Register_d = r_Shift_Register << 1;
                            r_Bit_Count_d      = r_Bit_Count + 1'b1;
                        end
                    end
`ifdef PISO_TX_PARITY_EN
                    PARITY: r_State_d = IDLE;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk_In) begin
        if (!Reset_In) begin
            r_State          <= IDLE;
            r_Shift_Register <= '0;
            r_Bit_Count      <= '0;
`ifdef PISO_TX_PARITY_EN
            r_Parity         <= 1'b0;
`endif
        end else begin
            r_State          <= r_State_d;
            r_Shift_Register <= r_Shift_Register_d;
            r_Bit_Count      <= r_Bit_Count_d;
`ifdef PISO_TX_PARITY_EN
            r_Parity         <= r_Parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_parallel_in_serial_out_tx.sv
// Self-checking bench for parallel_in_serial_out_tx: directed scenarios plus random traffic
// compared against a queue-of-pending-bits reference model.
module tb_parallel_in_serial_out_tx;

    localparam int DW = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME = DW + 1;
`else
    localparam int FRAME = DW;
`endif

    logic          clk = 1'b0;
    logic          Reset_In = 1'b0;
    logic          Enable_In = 1'b0;
    logic          Load_Valid_In = 1'b0;
    logic [DW-1:0] Parallel_Data_In = '0;
    logic          Ready_Out;
    logic          Serial_Data_Out;
    logic          Serial_Valid_Out;
    logic          Frame_Done_Out;

    parallel_in_serial_out_tx #(.DATA_WIDTH(DW)) dut (
        .Clk_In           (clk),
        .Reset_In         (Reset_In),
        .Enable_In        (Enable_In),
        .Load_Valid_In    (Load_Valid_In),
        .Parallel_Data_In (Parallel_Data_In),
        .Ready_Out        (Ready_Out),
        .Serial_Data_Out  (Serial_Data_Out),
        .Serial_Valid_Out (Serial_Valid_Out),
        .Frame_Done_Out   (Frame_Done_Out)
    );

    always #5 clk = ~clk;

    // Model: queue of bits still to appear on the line; the head is the bit on the line now.
    typedef struct packed {
        logic b;
        logic last;
    } ent_t;

    ent_t q[$];
    bit   known = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_valid, n_done, n_acc, run, max_run;

    task automatic chk(input string tag, input logic act, input logic exp);
        n_assert++;
        assert (act === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int act, input int exp);
        n_assert++;
        assert (act == exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        ent_t e;
        for (int i = DW - 1; i >= 0; i--) begin
            e.b = d[i];
`ifdef PISO_TX_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (i == 0);
`endif
            q.push_back(e);
        end
`ifdef PISO_TX_PARITY_EN
        e.b = ^d;
        e.last = 1'b1;
        q.push_back(e);
`endif
    endtask

    task automatic clear_counts();
        n_valid = 0; n_done = 0; n_acc = 0; run = 0; max_run = 0;
    endtask

    task automatic step(input logic en, input logic rst, input logic lv, input logic [DW-1:0] d);
        logic exp_rdy;
        logic acc;
        @(negedge clk);
        Enable_In = en; Reset_In = rst; Load_Valid_In = lv; Parallel_Data_In = d;
        #1;
        exp_rdy = en && (q.size() <= 1);
        if (!en) begin
            chk("data_z", Serial_Data_Out, 1'bz);
            chk("valid_dis", Serial_Valid_Out, 1'b0);
            chk("done_dis", Frame_Done_Out, 1'b0);
            chk("ready_dis", Ready_Out, 1'b0);
        end else begin
            if (known) chk("ready", Ready_Out, exp_rdy);
            if (!rst || q.size() == 0) begin
                chk("data_idle", Serial_Data_Out, 1'b0);
                chk("valid_idle", Serial_Valid_Out, 1'b0);
                chk("done_idle", Frame_Done_Out, 1'b0);
            end else begin
                chk("data", Serial_Data_Out, q[0].b);
                chk("valid", Serial_Valid_Out, 1'b1);
                chk("done", Frame_Done_Out, q[0].last);
            end
        end
        if (Serial_Valid_Out === 1'b1) begin
            n_valid++; run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (Frame_Done_Out === 1'b1) n_done++;
        acc = exp_rdy && lv && rst;
        if (acc) n_acc++;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            known = 1'b1;
        end else if (en) begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc) push_word(d);
        end
    endtask

    initial begin
        int guard;
        // Reset held two cycles while a word is offered
        clear_counts();
        step(1'b1, 1'b0, 1'b1, 8'hA5);
        step(1'b1, 1'b0, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("rdy_after_reset", Ready_Out, 1'b1);
        chk_int("reset_no_valid", n_valid, 0);

        // Single frame
        clear_counts();
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        repeat (FRAME + 3) step(1'b1, 1'b1, 1'b0, 8'h00);
        chk_int("single_valid_cnt", n_valid, FRAME);
        chk_int("single_done_cnt", n_done, 1);

        // Back-to-back words with the load held high
        clear_counts();
        guard = 0;
        while (n_acc < 2 && guard < 40) begin
            step(1'b1, 1'b1, 1'b1, (n_acc == 0) ? 8'hFF : 8'h01);
            guard++;
        end
        repeat (FRAME + 3) step(1'b1, 1'b1, 1'b0, 8'h00);
        chk_int("b2b_accepts", n_acc, 2);
        chk_int("b2b_valid_cnt", n_valid, 2 * FRAME);
        chk_int("b2b_contiguous", max_run, 2 * FRAME);
        chk_int("b2b_done_cnt", n_done, 2);

        // Enable freeze after the third bit
        clear_counts();
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (FRAME + 2) step(1'b1, 1'b1, 1'b0, 8'h00);
        chk_int("freeze_valid_cnt", n_valid, FRAME);
        chk_int("freeze_done_cnt", n_done, 1);

        // Load while busy, then reset in the middle of the frame
        clear_counts();
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h3C);
        chk("busy_ready", Ready_Out, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (4) step(1'b1, 1'b1, 1'b0, 8'h00);
        chk_int("busy_accepts", n_acc, 1);
        chk_int("abort_valid_cnt", n_valid, 4);
        chk_int("abort_done_cnt", n_done, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) != 0, ($urandom % 40) != 0, $urandom % 2, DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
